// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with HI/LO registers and
// sequencing controller for the E stage. Starting mult/div latches the
// full result into pending registers and commits it to HI/LO after a
// fixed latency; busy and stall_req feed the hazard unit.
// Optional build macro: MDU_CANCEL_EN adds a 'cancel' input that flushes
// an in-flight operation and blocks start/mthi/mtlo in the same cycle.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic        start,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        is_mdu_op_d,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned DW = 32;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MFHI  = 4'd4;
   localparam logic [3:0] OP_MFLO  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [DW-1:0]   hi_nxt, lo_nxt;
   logic [DW-1:0]   pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
   logic            pend_dz, pend_dz_nxt;
   logic            cancel_i;

   logic [2*DW-1:0]    prod_s, prod_u;
   logic signed [DW-1:0] quot_s, rem_s;
   logic [DW-1:0]      quot_u, rem_u;

`ifdef MDU_CANCEL_EN
   assign cancel_i = cancel;
`else
   assign cancel_i = 1'b0;
`endif

   // Combinational arithmetic on the forwarded operands, captured at start
   always_comb begin
      prod_s = $signed({{DW{rs_data[DW-1]}}, rs_data}) *
               $signed({{DW{rt_data[DW-1]}}, rt_data});
      prod_u = {{DW{1'b0}}, rs_data} * {{DW{1'b0}}, rt_data};
      quot_s = '0;
      rem_s  = '0;
      quot_u = '0;
      rem_u  = '0;
      if (rt_data != '0) begin
         quot_s = $signed(rs_data) / $signed(rt_data);
         rem_s  = $signed(rs_data) % $signed(rt_data);
         quot_u = rs_data / rt_data;
         rem_u  = rs_data % rt_data;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_dz <= pend_dz_nxt;
      end
   end

   // Next-state, latency counter, pending capture and HI/LO commit
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hi_nxt      = hi;
      lo_nxt      = lo;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_dz_nxt = pend_dz;
      case (state)
         IDLE: begin
            if (!cancel_i) begin
               if (start && (op == OP_MULT || op == OP_MULTU)) begin
                  pend_hi_nxt = (op == OP_MULT) ? prod_s[2*DW-1:DW] : prod_u[2*DW-1:DW];
                  pend_lo_nxt = (op == OP_MULT) ? prod_s[DW-1:0]    : prod_u[DW-1:0];
                  pend_dz_nxt = 1'b0;
                  cnt_nxt     = CNT_W'(MULT_CYCLES - 1);
                  state_nxt   = RUN;
               end else if (start && (op == OP_DIV || op == OP_DIVU)) begin
                  pend_hi_nxt = (op == OP_DIV) ? DW'(rem_s)  : rem_u;
                  pend_lo_nxt = (op == OP_DIV) ? DW'(quot_s) : quot_u;
                  pend_dz_nxt = (rt_data == '0);
                  cnt_nxt     = CNT_W'(DIV_CYCLES - 1);
                  state_nxt   = RUN;
               end else if (op == OP_MTHI) begin
                  hi_nxt = rs_data;
               end else if (op == OP_MTLO) begin
                  lo_nxt = rs_data;
               end
            end
         end
         RUN: begin
            if (cancel_i) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               pend_hi_nxt = '0;
               pend_lo_nxt = '0;
               pend_dz_nxt = 1'b0;
            end else if (cnt == '0) begin
               if (!pend_dz) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state == RUN);
   assign stall_req = is_mdu_op_d & (busy | start);

   // mfhi/mflo read port; shows the committed registers only
   always_comb begin
      case (op)
         OP_MFHI: result = hi;
         OP_MFLO: result = lo;
         default: result = '0;
      endcase
   end

endmodule
